// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared types and default sizes for the router port serializer.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        PAD  = 3'd2,
        DATA = 3'd3,
        WAIT = 3'd4
    } ser_state_t;

    localparam int ROUTER_PORTS   = 16;
    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 8;
    localparam int PAD_CYCLES_DEF = 5;

    // Counter width able to hold 0..limit-1, never narrower than one bit.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/port_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : port_shift_reg
// Brief    : Loadable LSB-first shift register; exposes the bit it will hold
//            at position 0 after the coming edge.
// Revision : 1.0 - initial release
// ============================================================================
module port_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    output logic             lsb_nxt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;

    always_comb begin
        w_q_nxt = r_q;
        if (load) begin
            w_q_nxt = load_val;
        end else if (shift) begin
            w_q_nxt = r_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    // Lets the owner register din in the same edge that updates the shifter.
    assign lsb_nxt = w_q_nxt[0];

endmodule
`default_nettype wire

// File: rtl/router_port_serializer.sv
`default_nettype none
// ============================================================================
// Module   : router_port_serializer
// Brief    : Turns a valid/ready byte stream into one router input port's
//            frame_n / valid_n / din serial protocol.
// Revision : 1.0 - initial release
// ============================================================================
module router_port_serializer #(
    parameter int ADDR_W     = router_pkg::ADDR_W,
    parameter int DATA_W     = router_pkg::DATA_W,
    parameter int PAD_CYCLES = router_pkg::PAD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              s_last,
    output logic              frame_n,
    output logic              valid_n,
    output logic              din,
    output logic              busy
);

    import router_pkg::*;

    localparam int C_AW   = cnt_w(ADDR_W);
    localparam int C_BW   = cnt_w(DATA_W);
    localparam int C_SR_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [C_AW-1:0] C_ADDR_LAST = C_AW'(ADDR_W - 1);
    localparam logic [C_BW-1:0] C_BIT_LAST  = C_BW'(DATA_W - 1);

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [C_AW-1:0]   r_addr_cnt;
    logic [C_AW-1:0]   w_addr_nxt;
    logic [C_BW-1:0]   r_bit_cnt;
    logic [C_BW-1:0]   w_bit_nxt;
    logic [DATA_W-1:0] r_byte;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_frame_n;
    logic              r_valid_n;
    logic              r_din;
    logic              w_accept;
    logic              w_byte_end;
    logic              w_byte_cap;
    logic              w_pad_done;
    logic              w_sr_load;
    logic              w_sr_shift;
    logic [C_SR_W-1:0] w_sr_val;
    logic              w_sr_lsb_nxt;

    assign w_byte_end = (r_state == DATA) && (r_bit_cnt == C_BIT_LAST);
    assign s_ready    = (r_state == IDLE) || (r_state == WAIT) || (w_byte_end && !r_last);
    assign w_accept   = s_valid && s_ready;
    assign w_byte_cap = (r_state == IDLE) && w_accept;
    assign busy       = (r_state != IDLE);
    assign frame_n    = r_frame_n;
    assign valid_n    = r_valid_n;
    assign din        = r_din;

    generate
        if (PAD_CYCLES > 0) begin : g_pad
            localparam int C_PW = cnt_w(PAD_CYCLES);
            logic [C_PW-1:0] r_pad_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pad_cnt <= '0;
                end else if ((r_state == PAD) && !w_pad_done) begin
                    r_pad_cnt <= r_pad_cnt + 1'b1;
                end else begin
                    r_pad_cnt <= '0;
                end
            end

            assign w_pad_done = (r_pad_cnt == C_PW'(PAD_CYCLES - 1));
        end else begin : g_no_pad
            assign w_pad_done = 1'b1;
        end
    endgenerate

    // The shifter first carries the zero-extended address, then each byte.
    port_shift_reg #(
        .WIDTH (C_SR_W)
    ) u_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_sr_load),
        .shift    (w_sr_shift),
        .load_val (w_sr_val),
        .lsb_nxt  (w_sr_lsb_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_last_nxt  = r_last;
        w_sr_load   = 1'b0;
        w_sr_shift  = 1'b0;
        w_sr_val    = C_SR_W'(r_byte);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ADDR;
                    w_addr_nxt  = '0;
                    w_last_nxt  = s_last;
                    w_sr_load   = 1'b1;
                    w_sr_val    = C_SR_W'(s_addr);
                end
            end
            ADDR: begin
                if (r_addr_cnt == C_ADDR_LAST) begin
                    if (PAD_CYCLES == 0) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                        w_sr_load   = 1'b1;
                    end else begin
                        w_state_nxt = PAD;
                    end
                end else begin
                    w_addr_nxt = r_addr_cnt + 1'b1;
                    w_sr_shift = 1'b1;
                end
            end
            PAD: begin
                if (w_pad_done) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_sr_load   = 1'b1;
                end
            end
            DATA: begin
                if (w_byte_end) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                    end else if (w_accept) begin
                        w_bit_nxt  = '0;
                        w_last_nxt = s_last;
                        w_sr_load  = 1'b1;
                        w_sr_val   = C_SR_W'(s_data);
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_bit_nxt  = r_bit_cnt + 1'b1;
                    w_sr_shift = 1'b1;
                end
            end
            WAIT: begin
                if (w_accept) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_last_nxt  = s_last;
                    w_sr_load   = 1'b1;
                    w_sr_val    = C_SR_W'(s_data);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_addr_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_frame_n  <= 1'b1;
            r_valid_n  <= 1'b1;
            r_din      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_cnt <= w_addr_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_last     <= w_last_nxt;
            if (w_byte_cap) begin
                r_byte <= s_data;
            end
            // frame_n lifts already during the final bit of the last byte.
            r_frame_n <= (w_state_nxt == IDLE) ||
                         ((w_state_nxt == DATA) && (w_bit_nxt == C_BIT_LAST) && w_last_nxt);
            r_valid_n <= (w_state_nxt != DATA);
            case (w_state_nxt)
                ADDR, DATA: r_din <= w_sr_lsb_nxt;
                PAD:        r_din <= 1'b1;
                default:    r_din <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_port_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_port_serializer
// Brief    : Directed cycle tables and reset sequence for the port serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_port_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_valid_a, s_valid_b;
    logic [7:0] s_data;
    logic [3:0] s_addr;
    logic       s_last;
    logic       s_ready_a, frame_n_a, valid_n_a, din_a, busy_a;
    logic       s_ready_b, frame_n_b, valid_n_b, din_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_port_serializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid_a),
        .s_ready (s_ready_a),
        .s_data  (s_data),
        .s_addr  (s_addr),
        .s_last  (s_last),
        .frame_n (frame_n_a),
        .valid_n (valid_n_a),
        .din     (din_a),
        .busy    (busy_a)
    );

    router_port_serializer #(
        .PAD_CYCLES (0)
    ) dut_np (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid_b),
        .s_ready (s_ready_b),
        .s_data  (s_data),
        .s_addr  (s_addr),
        .s_last  (s_last),
        .frame_n (frame_n_b),
        .valid_n (valid_n_b),
        .din     (din_b),
        .busy    (busy_b)
    );

    // One character per cycle; cycle 0 is the cycle in which the first byte is offered.
    typedef struct {
        string           nm;
        bit              np;
        logic [1:0][3:0] addr;
        logic [1:0][7:0] data;
        string           vld, lst, sel, fr, vn, dn, rd, bs;
    } scen_t;

    scen_t tab [5];

    function automatic string str(input string s);
        return s;
    endfunction

    function automatic string rep(input string s, input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    function automatic logic bitat(input string s, input int i);
        return s.getc(i) == "1";
    endfunction

    task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic set_scen(input int k, input string nm, input bit np,
                            input logic [1:0][3:0] addr, input logic [1:0][7:0] data,
                            input string vld, input string lst, input string sel,
                            input string fr, input string vn, input string dn,
                            input string rd, input string bs);
        tab[k].nm = nm;   tab[k].np = np;   tab[k].addr = addr; tab[k].data = data;
        tab[k].vld = vld; tab[k].lst = lst; tab[k].sel = sel;
        tab[k].fr = fr;   tab[k].vn = vn;   tab[k].dn = dn;
        tab[k].rd = rd;   tab[k].bs = bs;
    endtask

    task automatic run_scen(input int k);
        scen_t sc;
        logic  sel;
        sc = tab[k];
        for (int c = 0; c < sc.fr.len(); c++) begin
            @(posedge clk);
            #1;
            sel    = bitat(sc.sel, c);
            s_addr = sc.addr[sel];
            s_data = sc.data[sel];
            s_last = bitat(sc.lst, c);
            s_valid_a = sc.np ? 1'b0 : bitat(sc.vld, c);
            s_valid_b = sc.np ? bitat(sc.vld, c) : 1'b0;
            @(negedge clk);
            chk({sc.nm, ".frame_n"}, c, sc.np ? frame_n_b : frame_n_a, bitat(sc.fr, c));
            chk({sc.nm, ".valid_n"}, c, sc.np ? valid_n_b : valid_n_a, bitat(sc.vn, c));
            chk({sc.nm, ".din"},     c, sc.np ? din_b     : din_a,     bitat(sc.dn, c));
            chk({sc.nm, ".s_ready"}, c, sc.np ? s_ready_b : s_ready_a, bitat(sc.rd, c));
            chk({sc.nm, ".busy"},    c, sc.np ? busy_b    : busy_a,    bitat(sc.bs, c));
        end
        @(posedge clk);
        #1;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
    endtask

    initial begin
        set_scen(0, "one_byte", 1'b0, {4'h0, 4'h3}, {8'h00, 8'hA5},
                 {str("1"), rep("0", 18)}, {str("1"), rep("0", 18)}, rep("0", 19),
                 {str("1"), rep("0", 16), "11"},
                 {rep("1", 10), rep("0", 8), "1"},
                 {str("0"), "1100", "11111", "10100101", "0"},
                 {str("1"), rep("0", 17), "1"},
                 {str("0"), rep("1", 17), "0"});
        set_scen(1, "two_byte", 1'b0, {4'hA, 4'h6}, {8'hF0, 8'h0F},
                 {rep("1", 18), rep("0", 9)},
                 {str("0"), rep("1", 17), rep("0", 9)},
                 {str("0"), rep("1", 17), rep("0", 9)},
                 {str("1"), rep("0", 24), "11"},
                 {rep("1", 10), rep("0", 16), "1"},
                 {str("0"), "0110", "11111", "11110000", "00001111", "0"},
                 {str("1"), rep("0", 16), "1", rep("0", 8), "1"},
                 {str("0"), rep("1", 25), "0"});
        set_scen(2, "wait_gap", 1'b0, {4'hA, 4'h6}, {8'hF0, 8'h0F},
                 {str("1"), rep("0", 19), "1", rep("0", 9)},
                 {rep("0", 20), "1", rep("0", 9)},
                 {rep("0", 20), "1", rep("0", 9)},
                 {str("1"), rep("0", 27), "11"},
                 {rep("1", 10), rep("0", 8), rep("1", 3), rep("0", 8), "1"},
                 {str("0"), "0110", "11111", "11110000", "000", "00001111", "0"},
                 {str("1"), rep("0", 16), rep("1", 4), rep("0", 8), "1"},
                 {str("0"), rep("1", 28), "0"});
        set_scen(3, "back2back", 1'b0, {4'h9, 4'h5}, {8'h81, 8'h3C},
                 {rep("1", 19), rep("0", 18)},
                 {rep("1", 19), rep("0", 18)},
                 {str("0"), rep("1", 18), rep("0", 18)},
                 {str("1"), rep("0", 16), "11", rep("0", 16), "11"},
                 {rep("1", 10), rep("0", 8), rep("1", 10), rep("0", 8), "1"},
                 {str("0"), "1010", "11111", "00111100", "0", "1001", "11111", "10000001", "0"},
                 {str("1"), rep("0", 17), "1", rep("0", 17), "1"},
                 {str("0"), rep("1", 17), "0", rep("1", 17), "0"});
        set_scen(4, "no_pad", 1'b1, {4'h0, 4'hF}, {8'h00, 8'h01},
                 {str("1"), rep("0", 13)}, {str("1"), rep("0", 13)}, rep("0", 14),
                 {str("1"), rep("0", 11), "11"},
                 {rep("1", 5), rep("0", 8), "1"},
                 {str("0"), "1111", "10000000", "0"},
                 {str("1"), rep("0", 12), "1"},
                 {str("0"), rep("1", 12), "0"});

        reset_n   = 1'b0;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        s_data    = 8'h00;
        s_addr    = 4'h0;
        s_last    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.frame_n", 0, frame_n_a, 1'b1);
        chk("rst.valid_n", 0, valid_n_a, 1'b1);
        chk("rst.din",     0, din_a,     1'b0);
        chk("rst.busy",    0, busy_a,    1'b0);
        chk("rst.s_ready", 0, s_ready_a, 1'b1);
        chk("rst_np.frame_n", 0, frame_n_b, 1'b1);
        chk("rst_np.busy",    0, busy_b,    1'b0);
        #1 reset_n = 1'b1;

        for (int k = 0; k < 4; k++) run_scen(k);

        // Reset pulse while packet addr=2 sits in its pad field.
        @(posedge clk);
        #1;
        s_addr    = 4'h2;
        s_data    = 8'h5A;
        s_last    = 1'b1;
        s_valid_a = 1'b1;
        @(posedge clk);
        #1 s_valid_a = 1'b0;
        @(negedge clk);
        chk("abort.addr0", 1, din_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("abort.addr1", 2, din_a, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort.pad_frame_n", 6, frame_n_a, 1'b0);
        chk("abort.pad_valid_n", 6, valid_n_a, 1'b1);
        chk("abort.pad_din",     6, din_a,     1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort.async_frame_n", 6, frame_n_a, 1'b1);
        chk("abort.async_valid_n", 6, valid_n_a, 1'b1);
        chk("abort.async_din",     6, din_a,     1'b0);
        chk("abort.async_busy",    6, busy_a,    1'b0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("abort.post_s_ready", 7, s_ready_a, 1'b1);
        chk("abort.post_frame_n", 7, frame_n_a, 1'b1);
        chk("abort.post_busy",    7, busy_a,    1'b0);
        run_scen(0);

        run_scen(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
